// File: rtl/mux_sweep_gen.sv
// Exhaustive sweep generator and checker for an external 4:1 mux.
// Defining MUX_SWEEP_CAPTURE_EN records the index of the first failing vector.
module mux_sweep_gen #(
  parameter int NUM_VEC = 64,
  parameter int SETTLE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       sel0,
  output logic       sel1,
  output logic       busy,
  output logic       done,
  output logic [6:0] err_cnt,
  output logic       pass,
  output logic [5:0] first_fail,
  output logic       first_fail_vld
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

  localparam logic [5:0] LAST_VEC  = 6'(NUM_VEC - 1);
  localparam logic [3:0] WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t     state;
  logic [5:0] vec;
  logic [3:0] wait_cnt;
  logic       expected;
  logic       mismatch;
  logic [6:0] err_next;

  // Reference mux model, evaluated against the stimulus currently on the pins.
  always_comb begin
    expected = a;
    case ({sel1, sel0})
      2'b00:   expected = a;
      2'b01:   expected = b;
      2'b10:   expected = c;
      default: expected = d;
    endcase
    mismatch = (op != expected);
    err_next = (mismatch && (err_cnt != 7'd127)) ? err_cnt + 7'd1 : err_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      wait_cnt <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      c        <= 1'b0;
      d        <= 1'b0;
      sel0     <= 1'b0;
      sel1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec     <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
            busy    <= 1'b1;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          {sel1, sel0, d, c, b, a} <= vec;
          wait_cnt <= '0;
          state    <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        CHECK: begin
          err_cnt <= err_next;
          // pass is taken from err_next so the final vector's result counts.
          if (vec == LAST_VEC) begin
            done  <= 1'b1;
            pass  <= (err_next == 7'd0);
            state <= DONE;
          end else begin
            vec   <= vec + 6'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_SWEEP_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if ((state == IDLE) && start) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if ((state == CHECK) && mismatch && !first_fail_vld) begin
      first_fail     <= vec;
      first_fail_vld <= 1'b1;
    end
  end
`else
  assign first_fail     = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sweep_gen.sv
// Randomized self-checking bench for mux_sweep_gen against a cycle-count based model.
module tb_mux_sweep_gen;

  localparam int NV  = 64;
  localparam int ST  = 1;
  localparam int PER = 2 + ST;
  localparam int T   = PER * NV;
`ifdef MUX_SWEEP_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic op;
  logic a, b, c, d, sel0, sel1, busy, done, pass, first_fail_vld;
  logic [6:0] err_cnt;
  logic [5:0] first_fail;

  logic start_s = 1'b0;
  logic op_s;
  logic a_s, b_s, c_s, d_s, sel0_s, sel1_s, busy_s, done_s, pass_s, ffv_s;
  logic [6:0] err_s;
  logic [5:0] ff_s;

  int mode = 0;
  logic [63:0] flip = '0;
  bit chk_en = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux_sweep_gen #(.NUM_VEC(NV), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .c(c), .d(d), .sel0(sel0), .sel1(sel1),
    .busy(busy), .done(done), .err_cnt(err_cnt), .pass(pass),
    .first_fail(first_fail), .first_fail_vld(first_fail_vld)
  );

  mux_sweep_gen #(.NUM_VEC(1), .SETTLE(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .op(op_s),
    .a(a_s), .b(b_s), .c(c_s), .d(d_s), .sel0(sel0_s), .sel1(sel1_s),
    .busy(busy_s), .done(done_s), .err_cnt(err_s), .pass(pass_s),
    .first_fail(ff_s), .first_fail_vld(ffv_s)
  );

  function automatic logic ideal_of(input logic [5:0] v);
    logic [3:0] data;
    data = v[3:0];
    return data[v[5:4]];
  endfunction

  // Mux under test: 0 ideal, 1 stuck at 0, 2 select lines swapped, 3 ideal with random flips.
  function automatic logic resp(input logic [5:0] v, input int md, input logic [63:0] fl);
    logic [3:0] data;
    data = v[3:0];
    case (md)
      1:       return 1'b0;
      2:       return data[{v[4], v[5]}];
      3:       return ideal_of(v) ^ fl[v];
      default: return ideal_of(v);
    endcase
  endfunction

  assign op   = resp({sel1, sel0, d, c, b, a}, mode, flip);
  assign op_s = ideal_of({sel1_s, sel0_s, d_s, c_s, b_s, a_s});

  // Model: k counts edges since the accepting edge; vector v is driven at
  // k = v*PER+1 and judged at k = (v+1)*PER, done appears at k = T.
  bit m_active = 1'b0;
  int k = 0;
  int m_err = 0;
  bit m_pass = 1'b0;
  int m_ff = 0;
  bit m_ffv = 1'b0;
  int m_stim = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; k = 0; m_err = 0; m_pass = 1'b0;
      m_ff = 0; m_ffv = 1'b0; m_stim = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; k = 0; m_err = 0; m_pass = 1'b0;
        m_ff = 0; m_ffv = 1'b0;
      end
    end else begin
      k++;
      if (k > T) begin
        m_active = 1'b0;
      end else begin
        if ((k - 1) % PER == 0) m_stim = (k - 1) / PER;
        if (k % PER == 0) begin
          int v;
          v = k / PER - 1;
          if (resp(6'(v), mode, flip) != ideal_of(6'(v))) begin
            if (m_err < 127) m_err++;
            if (!m_ffv) begin
              m_ff = v;
              m_ffv = 1'b1;
            end
          end
          if (k == T) m_pass = (m_err == 0);
        end
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output("busy", int'(busy), int'(m_active));
      check_output("done", int'(done), int'(m_active && (k == T)));
      check_output("stim", int'({sel1, sel0, d, c, b, a}), m_stim);
      check_output("err_cnt", int'(err_cnt), m_err);
      check_output("pass", int'(pass), int'(m_pass));
      check_output("first_fail", int'(first_fail), CAP ? m_ff : 0);
      check_output("first_fail_vld", int'(first_fail_vld), CAP ? int'(m_ffv) : 0);
    end
  end

  // One sweep; with noise, start toggles randomly while the sweep is busy.
  task automatic apply_stimulus(input int md, input logic [63:0] fl, input bit hold, input bit noise);
    int n;
    @(negedge clk);
    mode = md;
    flip = fl;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    n = 0;
    while (n < T + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        if (!hold) start = 1'b0;
        break;
      end
      if (noise && !hold) start = 1'($urandom_range(0, 1));
    end
    check_output("done_latency", n, T);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int dn;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_stim", int'({sel1, sel0, d, c, b, a}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Single-vector instance: only vector 0, done two edges after accept.
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      check_output("small_stim", int'({sel1_s, sel0_s, d_s, c_s, b_s, a_s}), 0);
      if (done_s) break;
    end
    check_output("small_latency", n, 2);
    check_output("small_pass", int'(pass_s), 1);
    check_output("small_err", int'(err_s), 0);
    idle_cycles(2);

    apply_stimulus(0, '0, 1'b0, 1'b0);
    check_output("ideal_err", int'(err_cnt), 0);
    check_output("ideal_pass", int'(pass), 1);
    check_output("ideal_ffv", int'(first_fail_vld), 0);
    idle_cycles(3);

    apply_stimulus(1, '0, 1'b0, 1'b0);
    check_output("stuck_err", int'(err_cnt), 32);
    check_output("stuck_model_err", m_err, 32);
    check_output("stuck_pass", int'(pass), 0);
    check_output("stuck_ff", int'(first_fail), CAP ? 1 : 0);
    check_output("stuck_ffv", int'(first_fail_vld), CAP ? 1 : 0);
    idle_cycles(3);
    check_output("hold_err", int'(err_cnt), 32);

    apply_stimulus(2, '0, 1'b0, 1'b0);
    check_output("swap_err", int'(err_cnt), 16);
    check_output("swap_model_ff", m_ff, 18);
    check_output("swap_pass", int'(pass), 0);
    check_output("swap_ff", int'(first_fail), CAP ? 18 : 0);
    idle_cycles(3);

    // Reset during vector 10 abandons the sweep silently.
    @(negedge clk);
    mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_stim", int'({sel1, sel0, d, c, b, a}), 0);
    check_output("midrst_busy", int'(busy), 0);
    check_output("midrst_err", int'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    check_output("midrst_no_done", dn, 0);
    apply_stimulus(0, '0, 1'b0, 1'b0);
    check_output("after_rst_err", int'(err_cnt), 0);
    check_output("after_rst_pass", int'(pass), 1);
    idle_cycles(3);

    // Start held high: one sweep, one idle cycle, then a fresh sweep.
    apply_stimulus(0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_output("held_idle_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check_output("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    dn = 0;
    n = 0;
    while (n < T + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) dn++;
      if (!busy) break;
    end
    check_output("held_second_done", dn, 1);
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(int'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b0, 1'b1);
      idle_cycles(int'($urandom_range(1, 5)));
    end

    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
